// File: rtl/obi_pkg.sv
// Shared types and helpers for the OBI memory-side responder.
package obi_pkg;

  localparam int unsigned OBI_DATA_W = 32;
  localparam int unsigned BE_W       = OBI_DATA_W / 8;

  // Response payload carried from the accepting edge to rvalid.
  typedef struct packed {
    logic [OBI_DATA_W-1:0] rdata;
    logic                  err;
  } obi_resp_t;

  // True when the word index of a byte address falls inside a memory of
  // 'depth' words. The low two address bits never affect the result.
  function automatic logic word_in_range(input logic [63:0] addr, input int unsigned depth);
    return (addr >> 2) < 64'(depth);
  endfunction

endpackage

// File: rtl/obi_resp_delay.sv
// LATENCY-stage valid/payload shift register with synchronous clear.
// An entry pushed at one edge appears at the output LATENCY cycles later.
module obi_resp_delay #(
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic [LATENCY-1:0]                vld_q, vld_d;
  logic [LATENCY-1:0][PAYLOAD_W-1:0] pld_q, pld_d;

  // Shift every stage by one; stage 0 takes the new entry.
  always_comb begin
    vld_d    = vld_q;
    pld_d    = pld_q;
    vld_d[0] = in_valid;
    pld_d[0] = in_payload;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
      pld_d[i] = pld_q[i-1];
    end
  end

  // Stage registers; clear drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      pld_q <= '0;
    end else begin
      vld_q <= vld_d;
      pld_q <= pld_d;
    end
  end

  assign out_valid   = vld_q[LATENCY-1];
  assign out_payload = pld_q[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: byte-enabled word memory, fixed-latency
// in-order responses, bounded outstanding count and range errors.
module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned LATENCY         = 1,   // >= 1
  parameter int unsigned MAX_OUTSTANDING = 2    // >= 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                stall_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o
);

  localparam int unsigned BYTES     = DATA_W / 8;
  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PAYLOAD_W = DATA_W + 1;

  logic [DATA_W-1:0]    mem_q [DEPTH_WORDS];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 in_range;
  logic                 accept;
  logic [IDX_W-1:0]     idx;
  logic [DATA_W-1:0]    rsp_rdata_d;
  logic                 rsp_err_d;
  logic                 rsp_valid;
  logic [PAYLOAD_W-1:0] rsp_payload;

  assign in_range = word_in_range(64'(addr_i), DEPTH_WORDS);
  assign idx      = addr_i[IDX_W+1:2];

  // Grant while a slot is free; a slot retired by this cycle's rvalid counts as free.
  always_comb begin
    gnt_o = req_i & ~stall_i & ~rst &
            ((cnt_q - CNT_W'(rvalid_o)) < CNT_W'(MAX_OUTSTANDING));
  end

  assign accept = req_i & gnt_o;

  // Response payload captured at the accepting edge: read data or error flag.
  always_comb begin
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (accept) begin
      if (!in_range)  rsp_err_d   = 1'b1;
      else if (!we_i) rsp_rdata_d = mem_q[idx];
    end
  end

  // Byte-enabled write; out-of-range writes are dropped. Memory is never reset.
  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < int'(BYTES); k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Outstanding count: +1 on accept, -1 on rvalid, both cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rvalid_o)      cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && rvalid_o) cnt_d = cnt_q - CNT_W'(1);
  end

  // Outstanding count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  obi_resp_delay #(
    .LATENCY  (LATENCY),
    .PAYLOAD_W(PAYLOAD_W)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_payload ({rsp_rdata_d, rsp_err_d}),
    .out_valid  (rsp_valid),
    .out_payload(rsp_payload)
  );

  assign rvalid_o = rsp_valid;
  assign rdata_o  = rsp_valid ? rsp_payload[PAYLOAD_W-1:1] : '0;
  assign err_o    = rsp_valid & rsp_payload[0];

  a_cnt_max: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_W'(MAX_OUTSTANDING));
  a_cnt_underflow: assert property (@(posedge clk) disable iff (rst)
    !(rvalid_o && (cnt_q == '0)));

endmodule
